hist_eq_output_engine: RTL

//  Responder to the frame controller's output_start/output_done handshake. On start, walks every

---
 rtl/hist_eq_output_engine_if.sv | 74 +++++++
 rtl/hist_eq_output_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_eq_output_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : hist_eq_output_engine_if
//  Description : Bus bundle between the histogram-equalisation output engine
//                and its neighbours: the frame-controller handshake, the
//                pixel SRAM read port, the CDF SRAM read port and the output
//                frame-buffer write port.
//                master = engine side, slave = environment side.
//  Revision    : 1.0  initial release
// ============================================================================
interface hist_eq_output_engine_if #(
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 8,
    parameter int CDF_W  = 20
);

    // Controller handshake and frame parameters
    logic               output_start;
    logic               output_base_offset;
    logic [CDF_W-1:0]   Cdf_Min_Out;
    logic [CDF_W-1:0]   Divisor;
    logic               output_done;

    // Pixel SRAM read port ({bank, index})
    logic               pix_rd_en;
    logic [ADDR_W:0]    pix_addr;
    logic [PIX_W-1:0]   pix_rdata;

    // CDF SRAM read port ({bank, pixel value})
    logic               cdf_rd_en;
    logic [PIX_W:0]     cdf_addr;
    logic [CDF_W-1:0]   cdf_rdata;

    // Output frame-buffer write port
    logic               out_we;
    logic [ADDR_W-1:0]  out_addr;
    logic [PIX_W-1:0]   out_wdata;

    modport master (
        input  output_start,
        input  output_base_offset,
        input  Cdf_Min_Out,
        input  Divisor,
        output output_done,
        output pix_rd_en,
        output pix_addr,
        input  pix_rdata,
        output cdf_rd_en,
        output cdf_addr,
        input  cdf_rdata,
        output out_we,
        output out_addr,
        output out_wdata
    );

    modport slave (
        output output_start,
        output output_base_offset,
        output Cdf_Min_Out,
        output Divisor,
        input  output_done,
        input  pix_rd_en,
        input  pix_addr,
        output pix_rdata,
        input  cdf_rd_en,
        input  cdf_addr,
        output cdf_rdata,
        input  out_we,
        input  out_addr,
        input  out_wdata
    );

endinterface
`default_nettype wire

// File: rtl/hist_eq_output_engine.sv
`default_nettype none
// ============================================================================
//  Module      : hist_eq_output_engine
//  Description : Histogram-equalisation output pass. On output_start it walks
//                every pixel of the selected ping-pong bank, fetches the pixel
//                and its CDF entry, computes
//                    (sat_sub(cdf, cdf_min) * OUT_MAX) / Divisor
//                with an 8-step restoring divider and writes the result to the
//                output frame buffer. Each pixel takes exactly 12 cycles.
//                Finishes with a one-cycle output_done pulse.
//  Options     : HIST_EQ_ROUND_EN - when defined, Divisor>>1 is added to the
//                numerator so the divide rounds half up. Timing is unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
module hist_eq_output_engine #(
    parameter int NUM_PIXELS = 307200,
    parameter int ADDR_W     = 19,
    parameter int PIX_W      = 8,
    parameter int CDF_W      = 20,
    parameter int OUT_MAX    = 255
) (
    input  wire logic                clock,
    input  wire logic                reset,
    hist_eq_output_engine_if.master  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Numerator is a CDF difference times an OUT_MAX that fits in PIX_W bits.
    localparam int c_NUM_W     = CDF_W + PIX_W;
    // One quotient bit per DIV cycle; the quotient is PIX_W bits wide.
    localparam int c_DIV_STEPS = PIX_W;
    localparam int c_CNT_W     = (c_DIV_STEPS > 1) ? $clog2(c_DIV_STEPS) : 1;

    localparam logic [ADDR_W-1:0]  c_LAST_IDX  = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(c_DIV_STEPS - 1);
    localparam logic [PIX_W-1:0]   c_OUT_MAX   = PIX_W'(OUT_MAX);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_PIX   = 3'd1,
        S_RD_CDF   = 3'd2,
        S_LOAD     = 3'd3,
        S_DIV      = 3'd4,
        S_WRITE    = 3'd5,
        S_DONE     = 3'd6,
        S_WAIT_LOW = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Frame parameters captured when a frame is accepted
    logic                r_bank;
    logic [CDF_W-1:0]    r_cdf_min;
    logic [CDF_W-1:0]    r_div;
    logic [ADDR_W-1:0]   r_index;

    // Divider state
    logic [c_CNT_W-1:0]  r_step;
    logic [CDF_W-1:0]    r_rem;
    logic [PIX_W-1:0]    r_low;
    logic [PIX_W-1:0]    r_quot;
    logic                r_div_zero;
    logic                r_ovf;

    // Combinational datapath
    logic [CDF_W-1:0]    w_diff;
    logic [c_NUM_W-1:0]  w_prod;
    logic [c_NUM_W-1:0]  w_num;
    logic [CDF_W-1:0]    w_num_hi;
    logic [CDF_W:0]      w_trial;
    logic                w_qbit;
    logic [CDF_W-1:0]    w_rem_next;
    logic [PIX_W-1:0]    w_result;

    // Combinational outputs
    logic                w_done;
    logic                w_pix_rd_en;
    logic [ADDR_W:0]     w_pix_addr;
    logic                w_cdf_rd_en;
    logic [PIX_W:0]      w_cdf_addr;
    logic                w_out_we;
    logic [ADDR_W-1:0]   w_out_addr;
    logic [PIX_W-1:0]    w_out_wdata;

    // ------------------------------------------------------------------------
    // Numerator: saturating subtract, scale by OUT_MAX, optional rounding bias.
    // The CDF entry arrives the cycle after cdf_rd_en, i.e. during LOAD.
    // ------------------------------------------------------------------------
    assign w_diff = (bus.cdf_rdata > r_cdf_min) ? (bus.cdf_rdata - r_cdf_min) : '0;
    assign w_prod = c_NUM_W'(w_diff) * c_NUM_W'(OUT_MAX);

`ifdef HIST_EQ_ROUND_EN
    // Half the divisor biases the truncating divide into round-half-up.
    assign w_num = w_prod + c_NUM_W'(r_div >> 1);
`else
    assign w_num = w_prod;
`endif

    // Upper part of the numerator seeds the partial remainder. If it already
    // reaches the divisor the quotient would not fit in PIX_W bits, which can
    // only happen with inconsistent CDF data; that pixel saturates.
    assign w_num_hi = w_num[c_NUM_W-1:PIX_W];

    // ------------------------------------------------------------------------
    // One restoring-divide step: shift in the next numerator bit, subtract the
    // divisor if it fits. The remainder stays below the divisor, so the trial
    // value needs only one extra bit.
    // ------------------------------------------------------------------------
    assign w_trial    = {r_rem, r_low[PIX_W-1]};
    assign w_qbit     = (w_trial >= {1'b0, r_div});
    assign w_rem_next = CDF_W'(w_qbit ? (w_trial - {1'b0, r_div}) : w_trial);

    // Final pixel value: zero divisor writes 0, overflow and any quotient
    // above OUT_MAX clamp to OUT_MAX.
    assign w_result = r_div_zero           ? '0        :
                      r_ovf                ? c_OUT_MAX :
                      (r_quot > c_OUT_MAX) ? c_OUT_MAX :
                                             r_quot;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Advance the sequencer; reset abandons any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode. Every strobe is a single cycle, and
    // addresses/data are held at zero whenever their strobe is low.
    // ------------------------------------------------------------------------
    // Decode the next state and drive the memory strobes for the current one.
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_pix_rd_en  = 1'b0;
        w_pix_addr   = '0;
        w_cdf_rd_en  = 1'b0;
        w_cdf_addr   = '0;
        w_out_we     = 1'b0;
        w_out_addr   = '0;
        w_out_wdata  = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.output_start) begin
                    w_next_state = S_RD_PIX;
                end
            end
            S_RD_PIX: begin
                w_pix_rd_en  = 1'b1;
                w_pix_addr   = {r_bank, r_index};
                w_next_state = S_RD_CDF;
            end
            S_RD_CDF: begin
                // Pixel data returned this cycle addresses the CDF table.
                w_cdf_rd_en  = 1'b1;
                w_cdf_addr   = {r_bank, bus.pix_rdata};
                w_next_state = S_LOAD;
            end
            S_LOAD: begin
                w_next_state = S_DIV;
            end
            S_DIV: begin
                if (r_step == c_LAST_STEP) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_out_we    = 1'b1;
                w_out_addr  = r_index;
                w_out_wdata = w_result;
                if (r_index == c_LAST_IDX) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RD_PIX;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                // A start level still held from the finished frame must
                // drop before another frame can be accepted.
                if (!bus.output_start) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Latch frame parameters, step the pixel index and run the divider.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bank     <= 1'b0;
            r_cdf_min  <= '0;
            r_div      <= '0;
            r_index    <= '0;
            r_step     <= '0;
            r_rem      <= '0;
            r_low      <= '0;
            r_quot     <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Frame inputs are sampled only here; later changes are
                    // ignored until the next frame.
                    if (bus.output_start) begin
                        r_bank    <= bus.output_base_offset;
                        r_cdf_min <= bus.Cdf_Min_Out;
                        r_div     <= bus.Divisor;
                        r_index   <= '0;
                    end
                end
                S_LOAD: begin
                    r_rem      <= w_num_hi;
                    r_low      <= w_num[PIX_W-1:0];
                    r_quot     <= '0;
                    r_step     <= '0;
                    r_div_zero <= (r_div == '0);
                    r_ovf      <= (w_num_hi >= r_div);
                end
                S_DIV: begin
                    // The step counter always runs so a skipped divide still
                    // occupies the same number of cycles.
                    r_step <= r_step + 1'b1;
                    if (!r_div_zero && !r_ovf) begin
                        r_rem  <= w_rem_next;
                        r_low  <= {r_low[PIX_W-2:0], 1'b0};
                        r_quot <= {r_quot[PIX_W-2:0], w_qbit};
                    end
                end
                S_WRITE: begin
                    if (r_index != c_LAST_IDX) begin
                        r_index <= r_index + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------------
    assign bus.output_done = w_done;
    assign bus.pix_rd_en   = w_pix_rd_en;
    assign bus.pix_addr    = w_pix_addr;
    assign bus.cdf_rd_en   = w_cdf_rd_en;
    assign bus.cdf_addr    = w_cdf_addr;
    assign bus.out_we      = w_out_we;
    assign bus.out_addr    = w_out_addr;
    assign bus.out_wdata   = w_out_wdata;

endmodule
`default_nettype wire
